// File: rtl/cc_arbiter.sv
// cc_arbiter: round-robin arbiter and sequencer that time-shares one
// binary/Gray code converter datapath among NUM_REQ requesters.
// The converter input register (R1) and output capture register (R2) are
// strobed by r1_load / r2_load.
//
// Optional build macro: CC_ARB_LOCK_EN adds a per-requester lock input that,
// when high in ACK, keeps the round-robin pointer on the current winner so
// it can take back-to-back transactions.
//
// state | meaning
// IDLE  | no transaction; round-robin pick on the edge that sees any req
// LOAD  | operand held in R1, r1_load high
// CONV  | converter settling for CONV_CYCLES cycles, r2_load in the last one
// ACK   | result in rsp_data, one-cycle ack to the granted requester
module cc_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int WIDTH       = 8,
    parameter int CONV_CYCLES = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ-1:0]       req_mode,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
`ifdef CC_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]       lock,
`endif
    output logic [NUM_REQ-1:0]       gnt,
    output logic [NUM_REQ-1:0]       ack,
    output logic [WIDTH-1:0]         rsp_data,
    output logic                     busy,
    output logic [WIDTH-1:0]         cc_din,
    output logic                     cc_mode,
    input  logic [WIDTH-1:0]         cc_dout,
    output logic                     r1_load,
    output logic                     r2_load
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int SUM_W = PTR_W + 1;
    localparam int CNT_W = $clog2(CONV_CYCLES + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CONV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CONV_CYCLES - 1);
    localparam logic [PTR_W-1:0] PTR_MAX  = PTR_W'(NUM_REQ - 1);
    // With a single settle cycle the capture cycle is the first CONV cycle.
    localparam logic             R2_FIRST = (CONV_CYCLES == 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CONV = 2'd2,
        ST_ACK  = 2'd3
    } state_t;

    state_t             state, state_nxt;
    logic [PTR_W-1:0]   ptr, ptr_nxt;
    logic [PTR_W-1:0]   win, win_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [NUM_REQ-1:0] gnt_nxt, ack_nxt;
    logic [WIDTH-1:0]   rsp_nxt, din_nxt;
    logic               mode_nxt, r1_nxt, r2_nxt, busy_nxt;

    logic               pick_found;
    logic [PTR_W-1:0]   pick_idx;
    logic [SUM_W-1:0]   cand_sum;
    logic [PTR_W-1:0]   cand;
    logic [NUM_REQ-1:0] pick_onehot;
    logic [WIDTH-1:0]   pick_data;
    logic               pick_mode;

`ifdef CC_ARB_LOCK_EN
    logic               lock_hold, hold_nxt;
    logic               ptr_req;
    logic               win_lock;
`endif

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_MAX) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    // Round-robin search starting at ptr, wrapping modulo NUM_REQ.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand_sum   = '0;
        cand       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_sum = {1'b0, ptr} + SUM_W'(k);
            if (cand_sum >= SUM_W'(NUM_REQ)) begin
                cand_sum = cand_sum - SUM_W'(NUM_REQ);
            end
            cand = cand_sum[PTR_W-1:0];
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!pick_found && (cand == PTR_W'(i)) && req[i]) begin
                    pick_found = 1'b1;
                    pick_idx   = PTR_W'(i);
                end
            end
        end
    end

    // Decode the winner into a one-hot grant and select its operand and mode.
    always_comb begin
        pick_onehot = '0;
        pick_data   = '0;
        pick_mode   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_idx == PTR_W'(i)) begin
                pick_onehot[i] = 1'b1;
                pick_data      = req_data[i*WIDTH +: WIDTH];
                pick_mode      = req_mode[i];
            end
        end
    end

`ifdef CC_ARB_LOCK_EN
    // Request level at the pointer and lock level of the current winner.
    always_comb begin
        ptr_req  = 1'b0;
        win_lock = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ptr == PTR_W'(i)) begin
                ptr_req = req[i];
            end
            if (win == PTR_W'(i)) begin
                win_lock = lock[i];
            end
        end
    end
`endif

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        win_nxt   = win;
        cnt_nxt   = cnt;
        gnt_nxt   = gnt;
        ack_nxt   = '0;
        rsp_nxt   = rsp_data;
        din_nxt   = cc_din;
        mode_nxt  = cc_mode;
        r1_nxt    = 1'b0;
        r2_nxt    = 1'b0;
`ifdef CC_ARB_LOCK_EN
        hold_nxt  = lock_hold;
`endif
        case (state)
            ST_IDLE: begin
`ifdef CC_ARB_LOCK_EN
                // A held pointer lasts one IDLE visit; if the locked
                // requester has gone away, resume round robin after it.
                if (lock_hold) begin
                    hold_nxt = 1'b0;
                    if (!ptr_req) begin
                        ptr_nxt = ptr_inc(ptr);
                    end
                end
`endif
                if (pick_found) begin
                    win_nxt   = pick_idx;
                    gnt_nxt   = pick_onehot;
                    din_nxt   = pick_data;
                    mode_nxt  = pick_mode;
                    r1_nxt    = 1'b1;
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                cnt_nxt   = CNT_W'(1);
                r2_nxt    = R2_FIRST;
                state_nxt = ST_CONV;
            end
            ST_CONV: begin
                if (cnt == CNT_LAST) begin
                    rsp_nxt   = cc_dout;
                    ack_nxt   = gnt;
                    cnt_nxt   = '0;
                    state_nxt = ST_ACK;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                    r2_nxt  = (cnt == CNT_PRE);
                end
            end
            ST_ACK: begin
                gnt_nxt   = '0;
                ptr_nxt   = ptr_inc(win);
`ifdef CC_ARB_LOCK_EN
                if (win_lock) begin
                    ptr_nxt  = win;
                    hold_nxt = 1'b1;
                end
`endif
                state_nxt = ST_IDLE;
            end
            default: begin
                gnt_nxt   = '0;
                state_nxt = ST_IDLE;
            end
        endcase
        busy_nxt = (state_nxt != ST_IDLE);
    end

    // State, pointer, counter and output registers; reset aborts any transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            win       <= '0;
            cnt       <= '0;
            gnt       <= '0;
            ack       <= '0;
            rsp_data  <= '0;
            busy      <= 1'b0;
            cc_din    <= '0;
            cc_mode   <= 1'b0;
            r1_load   <= 1'b0;
            r2_load   <= 1'b0;
`ifdef CC_ARB_LOCK_EN
            lock_hold <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            win       <= win_nxt;
            cnt       <= cnt_nxt;
            gnt       <= gnt_nxt;
            ack       <= ack_nxt;
            rsp_data  <= rsp_nxt;
            busy      <= busy_nxt;
            cc_din    <= din_nxt;
            cc_mode   <= mode_nxt;
            r1_load   <= r1_nxt;
            r2_load   <= r2_nxt;
`ifdef CC_ARB_LOCK_EN
            lock_hold <= hold_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_cc_arbiter.sv
// Testbench for cc_arbiter: two instances (CONV_CYCLES=1 and 3), each with a
// combinational converter model, an expected-response queue and a monitor.
module tb_cc_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    typedef struct {
        int         idx;
        logic [7:0] data;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    int           cyc = 0;
    int           checks = 0;
    int           errors = 0;

    // instance a: CONV_CYCLES = 1
    logic [N-1:0]   req, req_mode, gnt, ack, lock;
    logic [N*W-1:0] req_data;
    logic [W-1:0]   rsp_data, cc_din, cc_dout;
    logic           busy, cc_mode, r1_load, r2_load;
    // instance b: CONV_CYCLES = 3
    logic [N-1:0]   req_b, req_mode_b, gnt_b, ack_b, lock_b;
    logic [N*W-1:0] req_data_b;
    logic [W-1:0]   rsp_data_b, cc_din_b, cc_dout_b;
    logic           busy_b, cc_mode_b, r1_load_b, r2_load_b;

    exp_t exp_a[$];
    exp_t exp_b[$];
    exp_t ea, eb;

    function automatic logic [7:0] conv(input logic [7:0] d, input logic m);
        logic [7:0] r;
        if (m) return d ^ (d >> 1);
        r[7] = d[7];
        for (int i = 6; i >= 0; i--) r[i] = r[i+1] ^ d[i];
        return r;
    endfunction

    assign cc_dout   = conv(cc_din, cc_mode);
    assign cc_dout_b = conv(cc_din_b, cc_mode_b);

    cc_arbiter #(.NUM_REQ(N), .WIDTH(W), .CONV_CYCLES(1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req(req), .req_mode(req_mode), .req_data(req_data),
`ifdef CC_ARB_LOCK_EN
        .lock(lock),
`endif
        .gnt(gnt), .ack(ack), .rsp_data(rsp_data), .busy(busy),
        .cc_din(cc_din), .cc_mode(cc_mode), .cc_dout(cc_dout),
        .r1_load(r1_load), .r2_load(r2_load)
    );

    cc_arbiter #(.NUM_REQ(N), .WIDTH(W), .CONV_CYCLES(3)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .req(req_b), .req_mode(req_mode_b), .req_data(req_data_b),
`ifdef CC_ARB_LOCK_EN
        .lock(lock_b),
`endif
        .gnt(gnt_b), .ack(ack_b), .rsp_data(rsp_data_b), .busy(busy_b),
        .cc_din(cc_din_b), .cc_mode(cc_mode_b), .cc_dout(cc_dout_b),
        .r1_load(r1_load_b), .r2_load(r2_load_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // monitor a: invariants every cycle, scoreboard pop on every ack
    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if (!$onehot0(gnt) || ((ack & ~gnt) != '0) || (r1_load && r2_load)) begin
                errors++;
                $display("FAIL invariant_a gnt=%b ack=%b r1=%b r2=%b", gnt, ack, r1_load, r2_load);
            end
            if (ack != '0) begin
                checks++;
                if (exp_a.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_ack_a got ack=%b rsp=%h want no ack", ack, rsp_data);
                end else begin
                    ea = exp_a.pop_front();
                    if (ack != (4'b0001 << ea.idx) || rsp_data != ea.data) begin
                        errors++;
                        $display("FAIL ack_a got ack=%b rsp=%h want ack=%b rsp=%h",
                                 ack, rsp_data, 4'b0001 << ea.idx, ea.data);
                    end
                end
            end
        end
    end

    // monitor b
    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if (!$onehot0(gnt_b) || ((ack_b & ~gnt_b) != '0) || (r1_load_b && r2_load_b)) begin
                errors++;
                $display("FAIL invariant_b gnt=%b ack=%b r1=%b r2=%b", gnt_b, ack_b, r1_load_b, r2_load_b);
            end
            if (ack_b != '0) begin
                checks++;
                if (exp_b.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_ack_b got ack=%b rsp=%h want no ack", ack_b, rsp_data_b);
                end else begin
                    eb = exp_b.pop_front();
                    if (ack_b != (4'b0001 << eb.idx) || rsp_data_b != eb.data) begin
                        errors++;
                        $display("FAIL ack_b got ack=%b rsp=%h want ack=%b rsp=%h",
                                 ack_b, rsp_data_b, 4'b0001 << eb.idx, eb.data);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_ack(input bit b, output int c);
        bit got;
        got = 1'b0;
        c   = -1;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            if (b ? (ack_b != '0) : (ack != '0)) begin
                got = 1'b1;
                c   = cyc;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL wait_ack timeout dut=%0d got no ack want ack within 30 cycles", b);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"},  32'(gnt), 32'h0);
        chk({tag, "_ack"},  32'(ack), 32'h0);
        chk({tag, "_rsp"},  32'(rsp_data), 32'h0);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
        chk({tag, "_din"},  32'(cc_din), 32'h0);
        chk({tag, "_mode"}, 32'(cc_mode), 32'h0);
        chk({tag, "_r1"},   32'(r1_load), 32'h0);
        chk({tag, "_r2"},   32'(r2_load), 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want $finish before 100000");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, prev;
        rst_n = 1'b0;
        req = '0; req_mode = '0; req_data = '0; lock = '0;
        req_b = '0; req_mode_b = '0; req_data_b = '0; lock_b = '0;
        repeat (2) step();
        chk_all_zero("reset");
        rst_n = 1'b1;
        step();

        // single transaction, binary->Gray, latency and strobe timing
        req = 4'b0001; req_mode = 4'b0001; req_data = {8'h00, 8'h00, 8'h00, 8'hCA};
        exp_a.push_back('{0, 8'hAF});
        step();
        chk("t1_load_gnt", 32'(gnt), 32'h1);
        chk("t1_load_r1", 32'(r1_load), 32'h1);
        chk("t1_load_r2", 32'(r2_load), 32'h0);
        chk("t1_load_busy", 32'(busy), 32'h1);
        chk("t1_load_din", 32'(cc_din), 32'hCA);
        chk("t1_load_mode", 32'(cc_mode), 32'h1);
        step();
        chk("t1_conv_gnt", 32'(gnt), 32'h1);
        chk("t1_conv_r1", 32'(r1_load), 32'h0);
        chk("t1_conv_r2", 32'(r2_load), 32'h1);
        chk("t1_conv_ack", 32'(ack), 32'h0);
        step();
        chk("t1_ack_ack", 32'(ack), 32'h1);
        chk("t1_ack_gnt", 32'(gnt), 32'h1);
        chk("t1_ack_r2", 32'(r2_load), 32'h0);
        req = '0;
        step();
        chk("t1_idle_busy", 32'(busy), 32'h0);
        chk("t1_idle_gnt", 32'(gnt), 32'h0);
        chk("t1_idle_ack", 32'(ack), 32'h0);
        chk("t1_idle_rsp_hold", 32'(rsp_data), 32'hAF);

        // Gray->binary on requester 2
        req = 4'b0100; req_mode = 4'b0000; req_data = {8'h00, 8'hAF, 8'h00, 8'h00};
        exp_a.push_back('{2, 8'hCA});
        wait_ack(1'b0, c);
        req = '0;
        step();

        // round robin from pointer 0 with all requests held
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        req = 4'b1111; req_mode = 4'b1111; req_data = {8'h08, 8'h04, 8'h02, 8'h01};
        exp_a.push_back('{0, 8'h01});
        exp_a.push_back('{1, 8'h03});
        exp_a.push_back('{2, 8'h06});
        exp_a.push_back('{3, 8'h0C});
        exp_a.push_back('{0, 8'h01});
        prev = 0;
        for (int k = 0; k < 5; k++) begin
            wait_ack(1'b0, c);
            if (k > 0) chk("rr_ack_spacing", 32'(c - prev), 32'd4);
            prev = c;
        end
        req = '0;
        repeat (2) step();

        // requester 1 drops req during CONV; requester 2 is served next
        req = 4'b0110; req_mode = 4'b0010; req_data = {8'h00, 8'h20, 8'h10, 8'h00};
        exp_a.push_back('{1, 8'h18});
        exp_a.push_back('{2, 8'h3F});
        step();
        step();
        req = 4'b0100;
        wait_ack(1'b0, prev);
        wait_ack(1'b0, c);
        chk("drop_next_spacing", 32'(c - prev), 32'd4);
        req = '0;
        repeat (2) step();

        // reset mid-CONV aborts without ack
        req = 4'b0001; req_mode = 4'b0001; req_data = {8'h00, 8'h00, 8'h00, 8'h55};
        step();
        step();
        chk("abort_in_conv_busy", 32'(busy), 32'h1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("abort");
        req = '0;
        step();
        rst_n = 1'b1;
        step();
        req = 4'b0100; req_mode = 4'b0100; req_data = {8'h00, 8'h33, 8'h00, 8'h00};
        exp_a.push_back('{2, 8'h2A});
        step();
        chk("post_abort_gnt", 32'(gnt), 32'h4);
        wait_ack(1'b0, c);
        req = '0;
        repeat (2) step();

        // CONV_CYCLES = 3 instance
        req_b = 4'b0010; req_mode_b = 4'b0000; req_data_b = {8'h00, 8'h00, 8'h0F, 8'h00};
        exp_b.push_back('{1, 8'h0A});
        wait_ack(1'b1, c);
        req_b = '0;
        step();

        req_b = 4'b1000; req_mode_b = 4'b1000; req_data_b = {8'h00, 8'h00, 8'h00, 8'h00};
        exp_b.push_back('{3, 8'h00});
        step();
        chk("c3_load_r1", 32'(r1_load_b), 32'h1);
        chk("c3_load_r2", 32'(r2_load_b), 32'h0);
        step();
        chk("c3_conv1_r1", 32'(r1_load_b), 32'h0);
        chk("c3_conv1_r2", 32'(r2_load_b), 32'h0);
        step();
        chk("c3_conv2_r2", 32'(r2_load_b), 32'h0);
        step();
        chk("c3_conv3_r2", 32'(r2_load_b), 32'h1);
        chk("c3_conv3_ack", 32'(ack_b), 32'h0);
        step();
        chk("c3_ack_ack", 32'(ack_b), 32'h8);
        chk("c3_ack_r2", 32'(r2_load_b), 32'h0);
        req_b = '0;
        step();
        chk("c3_idle_busy", 32'(busy_b), 32'h0);

        req_b = 4'b0001; req_mode_b = 4'b0001; req_data_b = {8'h00, 8'h00, 8'h00, 8'h0F};
        exp_b.push_back('{0, 8'h08});
        wait_ack(1'b1, c);
        req_b = '0;
        step();

`ifdef CC_ARB_LOCK_EN
        // lock[3] holds the pointer so requester 3 wins twice before 0
        req_b = 4'b1001; req_mode_b = 4'b1001; req_data_b = {8'h00, 8'h00, 8'h00, 8'h0F};
        lock_b = 4'b1000;
        exp_b.push_back('{3, 8'h00});
        exp_b.push_back('{3, 8'h00});
        exp_b.push_back('{0, 8'h08});
        wait_ack(1'b1, c);
        step();
        step();
        lock_b = '0;
        wait_ack(1'b1, c);
        wait_ack(1'b1, c);
        req_b = '0;
        repeat (2) step();
`endif

        repeat (3) step();
        chk("queue_a_drained", 32'(exp_a.size()), 32'h0);
        chk("queue_b_drained", 32'(exp_b.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
